// File: rtl/fma_dot_sequencer.sv
// Dot-product sequencer feeding an FMA datapath: acc <= acc + B*C per operand pair.
// Optional FMA_DOT_STATUS_EN adds status_o {denorm_seen, inf_seen}.
module fma_dot_sequencer #(
  parameter int unsigned PARM_EXP   = 8,
  parameter int unsigned PARM_MANT  = 23,
  parameter int unsigned PARM_LEN_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [PARM_LEN_W-1:0]         len_i,
  output logic                          busy_o,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [PARM_EXP+PARM_MANT:0]   in_b_i,
  input  logic [PARM_EXP+PARM_MANT:0]   in_c_i,
  output logic                          fma_req_o,
  output logic [PARM_EXP+PARM_MANT:0]   fma_a_o,
  output logic [PARM_EXP+PARM_MANT:0]   fma_b_o,
  output logic [PARM_EXP+PARM_MANT:0]   fma_c_o,
  input  logic                          fma_ack_i,
  input  logic                          fma_sign_i,
  input  logic [PARM_EXP-1:0]           fma_exp_i,
  input  logic [PARM_MANT-1:0]          fma_mant_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   out_data_o
`ifdef FMA_DOT_STATUS_EN
  ,
  output logic [1:0]                    status_o
`endif
);

  localparam int unsigned W = PARM_EXP + PARM_MANT + 1;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [PARM_LEN_W-1:0] len_q, len_d;
  logic [PARM_LEN_W-1:0] cnt_q, cnt_d;
  logic [PARM_LEN_W-1:0] cnt_inc;
  logic [W-1:0]          acc_q, acc_d;
  logic [W-1:0]          a_q, a_d;
  logic [W-1:0]          b_q, b_d;
  logic [W-1:0]          c_q, c_d;
  logic                  req_q, req_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  ov_q, ov_d;
  logic [W-1:0]          od_q, od_d;
  logic                  ack_take;
  logic [W-1:0]          fma_res;
`ifdef FMA_DOT_STATUS_EN
  logic [1:0]            flags_q, flags_d;
  logic [1:0]            stat_q, stat_d;
`endif

  assign fma_res  = {fma_sign_i, fma_exp_i, fma_mant_i};
  assign cnt_inc  = cnt_q + PARM_LEN_W'(1);
  assign ack_take = (state_q == S_WAIT) && fma_ack_i;

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
`ifdef FMA_DOT_STATUS_EN
    flags_d = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef FMA_DOT_STATUS_EN
          flags_d = 2'b00;
`endif
          state_d = (len_i == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        if (in_valid_i && rdy_q) begin
          a_d     = acc_q;
          b_d     = in_b_i;
          c_d     = in_c_i;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack_take) begin
          acc_d   = fma_res;
          cnt_d   = cnt_inc;
`ifdef FMA_DOT_STATUS_EN
          flags_d[0] = flags_q[0] | (&fma_exp_i);
          flags_d[1] = flags_q[1] | ((fma_exp_i == '0) && (fma_mant_i != '0));
`endif
          state_d = (cnt_inc == len_q) ? S_DONE : S_FEED;
        end
      end
      S_DONE: begin
        if (ov_q && out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered images of the upcoming state
    busy_d = (state_d != S_IDLE);
    rdy_d  = (state_d == S_FEED);
    req_d  = (state_d == S_WAIT);
    ov_d   = (state_d == S_DONE);
    od_d   = acc_d;
`ifdef FMA_DOT_STATUS_EN
    stat_d = flags_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      req_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
`ifdef FMA_DOT_STATUS_EN
      flags_q <= 2'b00;
      stat_q  <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      req_q   <= req_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
`ifdef FMA_DOT_STATUS_EN
      flags_q <= flags_d;
      stat_q  <= stat_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign in_ready_o  = rdy_q;
  assign fma_req_o   = req_q;
  assign fma_a_o     = a_q;
  assign fma_b_o     = b_q;
  assign fma_c_o     = c_q;
  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
`ifdef FMA_DOT_STATUS_EN
  assign status_o    = stat_q;
`endif

endmodule

// File: doc/fma_dot_sequencer.md
Name: fma_dot_sequencer

Overview:
- Sequencer directly downstream of the FMA rounding stage. Accumulates a dot product by repeated A + B*C.
- Accepts a stream of (B, C) single-precision operand pairs and issues each to the FMA datapath. The running accumulator is issued as A.
- Captures the rounded {sign, exp, mant} result and feeds it back as the next A. Presents the final sum on a valid/ready output.
- One instance per dot-product lane of the matrix accelerator.

Parameters:
- PARM_EXP, 8, exponent width.
- PARM_MANT, 23, stored mantissa width; word width W = PARM_EXP + PARM_MANT + 1.
- PARM_LEN_W, 8, width of vector-length field (max length 2^PARM_LEN_W - 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  start-of-vector pulse; sampled only in IDLE.
- len_i  in  PARM_LEN_W  vector length; latched on accepted start_i.
- busy_o  out  1  high in every state except IDLE.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  operand pair accepted when in_valid_i && in_ready_o.
- in_b_i  in  W  B operand (IEEE-754 bit pattern).
- in_c_i  in  W  C operand.
- fma_req_o  out  1  FMA request, level; held until ack.
- fma_a_o  out  W  accumulator operand to FMA.
- fma_b_o  out  W  registered B.
- fma_c_o  out  W  registered C.
- fma_ack_i  in  1  one-cycle pulse; result fields valid this cycle.
- fma_sign_i  in  1  rounded result sign.
- fma_exp_i  in  PARM_EXP  rounded result exponent.
- fma_mant_i  in  PARM_MANT  rounded result mantissa.
- out_valid_o  out  1  final dot product valid.
- out_ready_i  in  1  consumer ready.
- out_data_o  out  W  final result {sign, exp, mant}.

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator 0; count 0. Reset is asynchronous at any time, including mid-WAIT.
- States: IDLE, FEED, WAIT, DONE.
- IDLE:
  - start_i=1: latch len_i, clear accumulator to +0 (all zeros), clear count.
  - Go to DONE if len_i==0, else go to FEED.
- FEED:
  - in_ready_o=1.
  - On handshake: register B and C; next cycle assert fma_req_o with fma_a_o = accumulator; go to WAIT.
- WAIT:
  - fma_req_o=1; fma_a_o, fma_b_o and fma_c_o held stable until the fma_ack_i cycle.
  - On ack: accumulator <= {fma_sign_i, fma_exp_i, fma_mant_i}; count++; fma_req_o drops next cycle.
  - If count+1 == latched len, go to DONE; else go to FEED.
- DONE:
  - out_valid_o=1, out_data_o = accumulator, held stable until out_ready_i.
  - On out_valid_o && out_ready_i: go to IDLE, out_valid_o drops next cycle.
- Ignored inputs:
  - start_i outside IDLE.
  - fma_ack_i outside WAIT (including a late ack after reset).
  - in_valid_i outside FEED.
- Exactly one FMA request outstanding at a time. Minimum per-element cost is 2 cycles plus FMA latency.
- No arithmetic on the data path: the result fields are concatenated, not re-rounded. The count compare is unsigned, PARM_LEN_W bits, with no wrap (count < len always).
- len_i changing while busy has no effect.

Optional Feature:
- Macro: FMA_DOT_STATUS_EN.
- When defined, adds output status_o [1:0], valid with out_valid_o:
  - bit0 inf_seen: any captured result had exp all ones.
  - bit1 denorm_seen: any captured result had exp==0 and mant!=0.
  - Cleared on accepted start_i; reset value 0.
- When not defined, the port and flag logic are absent; all other behaviour is identical.

Test Plan:
- Basic sum: bench FMA model with latency 1. len=3, pairs (0x3F800000,0x40000000), (0x40000000,0x40000000), (0x40400000,0x3F800000) -> out_data_o=0x41100000 (9.0), exactly 3 fma_req_o assertions.
- Zero length: len=0 -> no fma_req_o; out_valid_o one cycle after start; out_data_o=0x00000000.
- Stall: out_ready_i low 5 cycles in DONE -> out_valid_o and out_data_o stable; start_i pulses ignored; busy_o=1.
- Latency and gaps: FMA latency 4, in_valid_i gaps of 2 cycles, len=4, all pairs (1.0,1.0) -> fma_req_o high 4 cycles per element with stable operands; result 0x40800000.
- Reset mid-operation: rst_n low during WAIT -> all outputs 0 immediately; a subsequent stray fma_ack_i is ignored; a new start works normally.
- FMA_DOT_STATUS_EN: one pair (0x7F800000, 0x3F800000), len=1 -> out_data_o=0x7F800000, status_o=2'b01; next start clears status_o.
